e_muldiv_iter: RTL and testbench

- Parametrised successor to the E-stage HI/LO multiply/divide unit in the MIPS pipeline.
- Supports signed and unsigned MULT/DIV, MTHI/MTLO, and accumulate modes MADD/MADDU/MSUB/MSUBU.
- Multiplication uses a configurable fixed latency. Division uses a true iterative radix-2 restoring divider.
- HI/LO commit only on completion. The hazard unit stalls on busy; IntReq suppresses any operation presented on an interrupt cycle.

---
 rtl/e_muldiv_iter.sv | 258 +++++++++++++++++++++++++
 tb/tb_e_muldiv_iter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/e_muldiv_iter.sv
// E-stage HI/LO multiply/divide unit.
// Multiplies (plain and multiply-accumulate) hold busy for a fixed
// MUL_CYCLES. Divides run a radix-2 restoring divider, one quotient bit
// per cycle, followed by a single sign-fix cycle. HI/LO change only when
// an operation completes, or directly on MTHI/MTLO.
module e_muldiv_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             IntReq,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               div0_r;
  logic [2*WIDTH-1:0] target_r;
  logic [WIDTH-1:0]   dvd_r;     // dividend bits still to be shifted in
  logic [WIDTH-1:0]   dvs_r;     // divisor magnitude
  logic [WIDTH-1:0]   rem_r;     // partial remainder
  logic [WIDTH-1:0]   quo_r;     // quotient bits collected so far
  logic               q_neg_r;
  logic               r_neg_r;
  logic               dz_r;

  logic               accept_s;
  logic               mul_signed_s;
  logic               acc_add_s;
  logic               acc_sub_s;
  logic               div_signed_s;
  logic [2*WIDTH-1:0] a_ext_s;
  logic [2*WIDTH-1:0] b_ext_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] target_s;
  logic [WIDTH-1:0]   a_abs_s;
  logic [WIDTH-1:0]   b_abs_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  assign busy = busy_r;
  assign done = done_r;
  assign div0 = div0_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

  // Decode the op, form the accumulate target, and compute one divider step.
  always_comb begin
    mul_signed_s = 1'b0;
    acc_add_s    = 1'b0;
    acc_sub_s    = 1'b0;
    case (op)
      OP_MULT:  mul_signed_s = 1'b1;
      OP_MADD:  begin mul_signed_s = 1'b1; acc_add_s = 1'b1; end
      OP_MADDU: acc_add_s = 1'b1;
      OP_MSUB:  begin mul_signed_s = 1'b1; acc_sub_s = 1'b1; end
      OP_MSUBU: acc_sub_s = 1'b1;
      default:  mul_signed_s = 1'b0;
    endcase

    if (mul_signed_s) begin
      a_ext_s = {{WIDTH{A[WIDTH-1]}}, A};
      b_ext_s = {{WIDTH{B[WIDTH-1]}}, B};
    end else begin
      a_ext_s = {{WIDTH{1'b0}}, A};
      b_ext_s = {{WIDTH{1'b0}}, B};
    end
    // Product of the two 2W-bit extensions, truncated: correct modulo 2^(2W).
    prod_s = a_ext_s * b_ext_s;

    if (acc_add_s) begin
      target_s = {hi_r, lo_r} + prod_s;
    end else if (acc_sub_s) begin
      target_s = {hi_r, lo_r} - prod_s;
    end else begin
      target_s = prod_s;
    end

    // Magnitudes for signed division; -MIN wraps to MIN, which is still
    // the correct unsigned magnitude 2^(W-1).
    div_signed_s = (op == OP_DIV);
    if (div_signed_s && A[WIDTH-1]) begin
      a_abs_s = -A;
    end else begin
      a_abs_s = A;
    end
    if (div_signed_s && B[WIDTH-1]) begin
      b_abs_s = -B;
    end else begin
      b_abs_s = B;
    end

    // Restoring step: shift in the next dividend bit, try a subtract.
    rem_shift_s = {rem_r, dvd_r[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_r};
    if (diff_s[WIDTH] == 1'b0) begin
      rem_next_s = diff_s[WIDTH-1:0];
      qbit_s     = 1'b1;
    end else begin
      rem_next_s = rem_shift_s[WIDTH-1:0];
      qbit_s     = 1'b0;
    end

    if (q_neg_r) begin
      quo_fix_s = -quo_r;
    end else begin
      quo_fix_s = quo_r;
    end
    if (r_neg_r) begin
      rem_fix_s = -rem_r;
    end else begin
      rem_fix_s = rem_r;
    end
  end

  assign accept_s = start && !IntReq && (state_r == ST_IDLE);

  // Control FSM together with HI/LO, datapath registers and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      div0_r   <= 1'b0;
      target_r <= {(2*WIDTH){1'b0}};
      dvd_r    <= {WIDTH{1'b0}};
      dvs_r    <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      div0_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (op)
              OP_MTHI: hi_r <= A;
              OP_MTLO: lo_r <= A;
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                target_r <= target_s;
                cnt_r    <= CNT_MUL;
                state_r  <= ST_MUL;
                busy_r   <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                dvd_r   <= a_abs_s;
                dvs_r   <= b_abs_s;
                rem_r   <= {WIDTH{1'b0}};
                quo_r   <= {WIDTH{1'b0}};
                q_neg_r <= div_signed_s && (A[WIDTH-1] ^ B[WIDTH-1]);
                r_neg_r <= div_signed_s && A[WIDTH-1];
                busy_r  <= 1'b1;
                if (B == {WIDTH{1'b0}}) begin
                  dz_r    <= 1'b1;
                  cnt_r   <= CNT_ZERO;
                  state_r <= ST_FIX;
                end else begin
                  dz_r    <= 1'b0;
                  cnt_r   <= CNT_DIV;
                  state_r <= ST_DIV;
                end
              end
              default: state_r <= ST_IDLE;
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_r == CNT_ZERO) begin
            hi_r    <= target_r[2*WIDTH-1:WIDTH];
            lo_r    <= target_r[WIDTH-1:0];
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DIV: begin
          rem_r <= rem_next_s;
          quo_r <= {quo_r[WIDTH-2:0], qbit_s};
          dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_FIX: begin
          if (dz_r) begin
            div0_r <= 1'b1;
          end else begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end
          dz_r    <= 1'b0;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_muldiv_iter.sv
// Directed testbench for e_muldiv_iter with WIDTH=32, MUL_CYCLES=5.
module tb_e_muldiv_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        irq;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int nbusy;
  int mid_done;
  logic end_done;
  logic end_div0;

  e_muldiv_iter #(.WIDTH(32), .MUL_CYCLES(5), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a_in), .B(b_in),
    .IntReq(irq), .busy(busy), .done(done), .div0(div0), .HI(hi), .LO(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op for one cycle, then count busy cycles until idle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic intr);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b; irq = intr;
    @(negedge clk);
    start = 1'b0; irq = 1'b0; op = 4'd15;
    nbusy = 0;
    mid_done = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      if (done) mid_done++;
      nbusy++;
      @(negedge clk);
    end
    end_done = done;
    end_div0 = div0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 4'd15; a_in = 32'd0; b_in = 32'd0; irq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_flags", {62'd0, done, div0}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;

    // MULT -2 * 3
    run_op(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_busy", 64'(nbusy), 64'd5);
    check("mult_done_end", {63'd0, end_done}, 64'd1);
    check("mult_done_mid", 64'(mid_done), 64'd0);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk);
    check("mult_done_clr", {63'd0, done}, 64'd0);

    // MULTU max * max
    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_busy", 64'(nbusy), 64'd5);
    check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // MTHI / MTLO then accumulate
    run_op(4'd4, 32'h0000_0001, 32'd0, 1'b0);
    check("mthi_busy", 64'(nbusy), 64'd0);
    check("mthi_done", {63'd0, end_done}, 64'd0);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
    check("mtlo_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
    run_op(4'd7, 32'd1, 32'd1, 1'b0);
    check("maddu_busy", 64'(nbusy), 64'd5);
    check("maddu_hilo", {hi, lo}, 64'h0000_0002_0000_0000);
    run_op(4'd8, 32'd1, 32'd1, 1'b0);
    check("msub_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFF);

    // Signed divides
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_busy", 64'(nbusy), 64'd33);
    check("div_done_end", {63'd0, end_done}, 64'd1);
    check("div_div0", {63'd0, end_div0}, 64'd0);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_minneg", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(4'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
    check("div_pos_neg", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    run_op(4'd3, 32'd100, 32'd7, 1'b0);
    check("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // Divide by zero leaves HI/LO alone
    run_op(4'd4, 32'h11, 32'd0, 1'b0);
    run_op(4'd5, 32'h22, 32'd0, 1'b0);
    run_op(4'd3, 32'd100, 32'd0, 1'b0);
    check("dz_busy", 64'(nbusy), 64'd1);
    check("dz_done", {63'd0, end_done}, 64'd1);
    check("dz_div0", {63'd0, end_div0}, 64'd1);
    check("dz_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    @(negedge clk);
    check("dz_div0_clr", {63'd0, div0}, 64'd0);

    // Suppressed by interrupt, and a reserved opcode
    run_op(4'd0, 32'd5, 32'd6, 1'b1);
    check("irq_busy", 64'(nbusy), 64'd0);
    check("irq_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    run_op(4'd12, 32'd5, 32'd6, 1'b0);
    check("nop_busy", 64'(nbusy), 64'd0);
    check("nop_hilo", {hi, lo}, 64'h0000_0011_0000_0022);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 4'd2; a_in = 32'd1000; b_in = 32'd3;
    @(negedge clk);
    start = 1'b0; op = 4'd15;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(4'd0, 32'd3, 32'd4, 1'b0);
    check("post_rst_busy", 64'(nbusy), 64'd5);
    check("post_rst_mult", {hi, lo}, 64'h0000_0000_0000_000C);

    // Signed and unsigned accumulate with carries across HI/LO
    run_op(4'd6, 32'hFFFF_FFFF, 32'd5, 1'b0);
    check("madd_neg", {hi, lo}, 64'h0000_0000_0000_0007);
    run_op(4'd9, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("msubu_wrap", {hi, lo}, 64'hFFFF_FFFE_0000_0009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
